// File: rtl/seq_btn_en_gen_autorepeat_if.sv
// Button-side signal bundle: raw button in, enable pulse and debounced level out.
interface seq_btn_en_gen_autorepeat_if;
    logic btn;
    logic en;
    logic held;

    modport master (output btn, input en, input held);
    modport slave  (input btn, output en, output held);
endinterface

// File: rtl/seq_btn_en_gen_autorepeat.sv
// Pushbutton to counter-enable converter: synchronizer, debouncer and press/auto-repeat FSM.
module seq_btn_en_gen_autorepeat #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 3,
    parameter int REPEAT_EN       = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    seq_btn_en_gen_autorepeat_if.slave    bus
);

    localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY - 1 : REPEAT_PERIOD - 1;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] DELAY_LOAD  = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] PERIOD_LOAD = TMR_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DELAY    = 2'd1,
        REPEAT   = 2'd2,
        WAIT_REL = 2'd3
    } state_t;

    logic             s1_q;
    logic             s2_q;
    logic [DB_W-1:0]  db_cnt_q;
    logic [DB_W-1:0]  db_cnt_d;
    logic             held_q;
    logic             held_d;
    state_t           state_q;
    logic [TMR_W-1:0] timer_q;
    logic             en_q;
    logic             held_rise;
    logic             held_fall;

    always_comb begin
        db_cnt_d = '0;
        held_d   = held_q;
        if (s2_q != held_q) begin
            if (db_cnt_q == DB_LAST) begin
                held_d = ~held_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // The FSM reacts on the same edge that flips held, so en and held rise together.
    assign held_rise = held_d & ~held_q;
    assign held_fall = ~held_d & held_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            db_cnt_q <= '0;
            held_q   <= 1'b0;
        end else begin
            s1_q     <= bus.btn;
            s2_q     <= s1_q;
            db_cnt_q <= db_cnt_d;
            held_q   <= held_d;
        end
    end

    // Release takes priority over everything, including a timer expiring on the same edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            en_q    <= 1'b0;
        end else begin
            en_q <= 1'b0;
            if (held_fall) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (held_rise) begin
                            en_q <= 1'b1;
                            if (REPEAT_EN != 0) begin
                                timer_q <= DELAY_LOAD;
                                state_q <= DELAY;
                            end else begin
                                state_q <= WAIT_REL;
                            end
                        end
                    end
                    DELAY, REPEAT: begin
                        if (timer_q == '0) begin
                            en_q    <= 1'b1;
                            timer_q <= PERIOD_LOAD;
                            state_q <= REPEAT;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= state_q;
                    end
                endcase
            end
        end
    end

    assign bus.en   = en_q;
    assign bus.held = held_q;

endmodule

// File: tb/tb_seq_btn_en_gen_autorepeat.sv
// Bench for the button enable generator: two instances (auto-repeat on/off) against a cycle-level behavioural model.
module tb_seq_btn_en_gen_autorepeat;

    localparam int DB = 4;
    localparam int RD = 8;
    localparam int RP = 3;

    logic clk;
    logic reset;
    logic btn;

    int vectors;
    int miscompares;

    seq_btn_en_gen_autorepeat_if ifa ();
    seq_btn_en_gen_autorepeat_if ifb ();

    assign ifa.btn = btn;
    assign ifb.btn = btn;

    seq_btn_en_gen_autorepeat #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(1)
    ) u_dut0 (
        .clk(clk), .reset(reset), .bus(ifa)
    );

    seq_btn_en_gen_autorepeat #(
        .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .REPEAT_EN(0)
    ) u_dut1 (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    // Model state, index 0 = auto-repeat instance, index 1 = single-pulse instance.
    bit m_s1[2];
    bit m_s2[2];
    bit m_held[2];
    bit m_en[2];
    int m_run[2];
    int m_age[2];

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_held[i] = 0; m_en[i] = 0;
            m_run[i] = 0; m_age[i] = 0;
        end
    endtask

    // held flips after DB consecutive mismatching synchronized samples; pulses at press age 0, RD, RD+RP, ...
    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            bit rose;
            rose = 0;
            if (m_s2[i] != m_held[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    m_held[i] = ~m_held[i];
                    m_run[i]  = 0;
                    rose      = m_held[i];
                end
            end else begin
                m_run[i] = 0;
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = btn;
            if (rose) begin
                m_en[i]  = 1;
                m_age[i] = 0;
            end else if (m_held[i] && i == 0) begin
                m_age[i]++;
                m_en[i] = (m_age[i] >= RD) && (((m_age[i] - RD) % RP) == 0);
            end else begin
                m_en[i] = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        btn   = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        btn   = 1'b0;
        model_clear();
        #2;
        vectors++;
        if (ifa.en !== 1'b0 || ifa.held !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dut0: en=%b held=%b, expected en=0 held=0", ifa.en, ifa.held);
        end
        vectors++;
        if (ifb.en !== 1'b0 || ifb.held !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_dut1: en=%b held=%b, expected en=0 held=0", ifb.en, ifb.held);
        end
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        for (int e = 0; e < 8; e++) begin
            step();
            vectors++;
            if (ifa.en !== m_en[0] || ifa.held !== m_held[0]) begin
                miscompares++;
                $display("FAIL reset_idle edge %0d: en=%b held=%b, expected en=%b held=%b",
                         e, ifa.en, ifa.held, m_en[0], m_held[0]);
            end
        end
    endtask

    task automatic test_clean_press();
        int rise_e = -1;
        int fall_e = -1;
        int pulses = 0;
        do_reset();
        for (int e = 0; e < 20; e++) begin
            btn = (e < 6);
            step();
            vectors++;
            if (ifa.en !== m_en[0] || ifa.held !== m_held[0]) begin
                miscompares++;
                $display("FAIL clean_dut0 edge %0d: en=%b held=%b, expected en=%b held=%b",
                         e, ifa.en, ifa.held, m_en[0], m_held[0]);
            end
            vectors++;
            if (ifb.en !== m_en[1] || ifb.held !== m_held[1]) begin
                miscompares++;
                $display("FAIL clean_dut1 edge %0d: en=%b held=%b, expected en=%b held=%b",
                         e, ifb.en, ifb.held, m_en[1], m_held[1]);
            end
            if (ifa.held === 1'b1 && rise_e < 0) rise_e = e;
            if (ifa.held === 1'b0 && rise_e >= 0 && fall_e < 0) fall_e = e;
            if (ifa.en === 1'b1) pulses++;
        end
        vectors++;
        if (rise_e != 5 || fall_e != 11 || pulses != 1) begin
            miscompares++;
            $display("FAIL clean_timing: rise=%0d fall=%0d pulses=%0d, expected rise=5 fall=11 pulses=1",
                     rise_e, fall_e, pulses);
        end
    endtask

    task automatic test_bounce();
        int first_en = -1;
        int pulses   = 0;
        do_reset();
        for (int e = 0; e < 15; e++) begin
            btn = (e < 4) ? ((e % 2) == 0) : 1'b1;
            step();
            vectors++;
            if (ifa.en !== m_en[0] || ifa.held !== m_held[0]) begin
                miscompares++;
                $display("FAIL bounce_dut0 edge %0d: en=%b held=%b, expected en=%b held=%b",
                         e, ifa.en, ifa.held, m_en[0], m_held[0]);
            end
            if (ifa.en === 1'b1) begin
                pulses++;
                if (first_en < 0) first_en = e;
            end
        end
        vectors++;
        if (first_en != 9 || pulses != 1) begin
            miscompares++;
            $display("FAIL bounce_timing: first_en=%0d pulses=%0d, expected first_en=9 pulses=1",
                     first_en, pulses);
        end
    endtask

    task automatic test_autorepeat();
        int got[$];
        int exp_e[$] = '{5, 13, 16, 19, 22};
        int pulses_b = 0;
        bit prev = 0;
        bit dbl  = 0;
        do_reset();
        for (int e = 0; e < 32; e++) begin
            btn = (e < 19);
            step();
            vectors++;
            if (ifa.en !== m_en[0] || ifa.held !== m_held[0]) begin
                miscompares++;
                $display("FAIL repeat_dut0 edge %0d: en=%b held=%b, expected en=%b held=%b",
                         e, ifa.en, ifa.held, m_en[0], m_held[0]);
            end
            if (ifa.en === 1'b1) begin
                got.push_back(e);
                if (prev) dbl = 1;
            end
            prev = (ifa.en === 1'b1);
            if (ifb.en === 1'b1) pulses_b++;
        end
        vectors++;
        if (got.size() != exp_e.size()) begin
            miscompares++;
            $display("FAIL repeat_count: %0d pulses, expected %0d", got.size(), exp_e.size());
        end else begin
            for (int i = 0; i < exp_e.size(); i++) begin
                vectors++;
                if (got[i] != exp_e[i]) begin
                    miscompares++;
                    $display("FAIL repeat_pulse[%0d]: edge %0d, expected edge %0d", i, got[i], exp_e[i]);
                end
            end
        end
        vectors++;
        if (dbl || pulses_b != 1) begin
            miscompares++;
            $display("FAIL repeat_shape: back_to_back=%0d dut1_pulses=%0d, expected back_to_back=0 dut1_pulses=1",
                     dbl, pulses_b);
        end
    endtask

    task automatic test_repeat_disabled();
        int pulses_b = 0;
        do_reset();
        for (int e = 0; e < 40; e++) begin
            btn = (e < 30);
            step();
            vectors++;
            if (ifb.en !== m_en[1] || ifb.held !== m_held[1]) begin
                miscompares++;
                $display("FAIL norepeat_dut1 edge %0d: en=%b held=%b, expected en=%b held=%b",
                         e, ifb.en, ifb.held, m_en[1], m_held[1]);
            end
            if (ifb.en === 1'b1) pulses_b++;
        end
        vectors++;
        if (pulses_b != 1) begin
            miscompares++;
            $display("FAIL norepeat_count: %0d pulses, expected 1", pulses_b);
        end
    endtask

    task automatic test_release_on_expiry();
        int pulses = 0;
        int first_en = -1;
        bit en13 = 1'b1;
        bit held13 = 1'b1;
        do_reset();
        for (int e = 0; e < 20; e++) begin
            btn = (e < 8);
            step();
            vectors++;
            if (ifa.en !== m_en[0] || ifa.held !== m_held[0]) begin
                miscompares++;
                $display("FAIL expiry_dut0 edge %0d: en=%b held=%b, expected en=%b held=%b",
                         e, ifa.en, ifa.held, m_en[0], m_held[0]);
            end
            if (e == 13) begin
                en13   = ifa.en;
                held13 = ifa.held;
            end
            if (ifa.en === 1'b1) pulses++;
        end
        vectors++;
        if (en13 !== 1'b0 || held13 !== 1'b0 || pulses != 1) begin
            miscompares++;
            $display("FAIL expiry_race: en@13=%b held@13=%b pulses=%0d, expected en=0 held=0 pulses=1",
                     en13, held13, pulses);
        end
        // A fresh press afterwards must behave like a press from idle.
        for (int e = 0; e < 10; e++) begin
            btn = 1'b1;
            step();
            if (ifa.en === 1'b1 && first_en < 0) first_en = e;
        end
        vectors++;
        if (first_en != 5) begin
            miscompares++;
            $display("FAIL expiry_repress: first en at edge %0d, expected 5", first_en);
        end
        btn = 1'b0;
    endtask

    task automatic test_mid_press_reset();
        int first_en = -1;
        do_reset();
        for (int e = 0; e < 16; e++) begin
            btn = 1'b1;
            step();
            vectors++;
            if (ifa.en !== m_en[0] || ifa.held !== m_held[0]) begin
                miscompares++;
                $display("FAIL midreset_pre edge %0d: en=%b held=%b, expected en=%b held=%b",
                         e, ifa.en, ifa.held, m_en[0], m_held[0]);
            end
        end
        #3;
        reset = 1'b1;
        model_clear();
        #1;
        vectors++;
        if (ifa.en !== 1'b0 || ifa.held !== 1'b0 || ifb.held !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_async: en=%b held=%b held1=%b, expected all 0",
                     ifa.en, ifa.held, ifb.held);
        end
        repeat (2) step();
        #3;
        reset = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            step();
            vectors++;
            if (ifa.en !== m_en[0] || ifa.held !== m_held[0]) begin
                miscompares++;
                $display("FAIL midreset_post edge %0d: en=%b held=%b, expected en=%b held=%b",
                         e, ifa.en, ifa.held, m_en[0], m_held[0]);
            end
            if (ifa.en === 1'b1 && first_en < 0) first_en = e;
        end
        vectors++;
        if (first_en != DB + 2) begin
            miscompares++;
            $display("FAIL midreset_latency: first en at edge %0d after release, expected %0d",
                     first_en, DB + 2);
        end
        btn = 1'b0;
    endtask

    task automatic test_random();
        do_reset();
        for (int seg = 0; seg < 80; seg++) begin
            bit lvl;
            int len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 14);
            for (int c = 0; c < len; c++) begin
                btn = lvl;
                step();
                vectors++;
                if (ifa.en !== m_en[0] || ifa.held !== m_held[0]) begin
                    miscompares++;
                    $display("FAIL random_dut0 seg %0d: en=%b held=%b, expected en=%b held=%b",
                             seg, ifa.en, ifa.held, m_en[0], m_held[0]);
                end
                vectors++;
                if (ifb.en !== m_en[1] || ifb.held !== m_held[1]) begin
                    miscompares++;
                    $display("FAIL random_dut1 seg %0d: en=%b held=%b, expected en=%b held=%b",
                             seg, ifb.en, ifb.held, m_en[1], m_held[1]);
                end
            end
            if ($urandom_range(0, 24) == 0) begin
                #2;
                reset = 1'b1;
                model_clear();
                #2;
                reset = 1'b0;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        btn         = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_autorepeat();
        test_repeat_disabled();
        test_release_on_expiry();
        test_mid_press_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
